// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register: state encoding,
// default field widths and control-bit positions used by every stage wrapper.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_CTRL_LEN = 8;
    localparam int PIPE_DATA_LEN = 96;

    // Control-field bit positions, shared so all stages pack ctrl identically.
    localparam int IDEX_MEM_READ   = 0;
    localparam int IDEX_MEM_WRITE  = 1;
    localparam int IDEX_WB_EN      = 2;
    localparam int IDEX_STATUS_WEN = 3;
    localparam int IDEX_BRANCH     = 4;

    // Number of valid entries held in a given state.
    function automatic logic [1:0] held_entries(input pipe_state_e st);
        case (st)
            PIPE_ONE: held_entries = 2'd1;
            PIPE_TWO: held_entries = 2'd2;
            default:  held_entries = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: adds 0..3 per cycle, sticks at all-ones,
// synchronous clear wins over any increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W+1:0] sum;

    // Next count: clear, saturate on overflow, or plain add.
    always_comb begin
        sum = {2'b00, cnt_q} + {{W{1'b0}}, inc};
        if (clr) begin
            cnt_d = '0;
        end else if (sum > {2'b00, {W{1'b1}}}) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with optional 2-entry skid buffer,
// synchronous flush, hazard stall and saturating stall/kill counters.
//
// state      | meaning
// -----------+--------------------------------------------------
// PIPE_EMPTY | nothing held, out_valid low
// PIPE_ONE   | main register valid and presented downstream
// PIPE_TWO   | main and skid both valid (SKID=1 only), in_ready low
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_LEN,
    parameter int DATA_W = PIPE_DATA_LEN,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hazard,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    pipe_state_e       state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic              accept;
    logic              drain;
    logic [1:0]        held_left;
    logic [1:0]        kill_inc;
    logic [1:0]        stall_inc;

    // Upstream ready: with the skid buffer it depends only on state, so
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        if (SKID) begin
            in_ready = rst & ~hazard & (state_q != PIPE_TWO);
        end else begin
            in_ready = rst & ~hazard & (~out_valid_q | out_ready);
        end
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid_q & out_ready;

    // Next-state and datapath selection; flush overrides everything but
    // leaves the data registers untouched.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = PIPE_EMPTY;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (accept) begin
                        state_d     = PIPE_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                PIPE_ONE: begin
                    if (accept && drain) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept && SKID) begin
                        state_d     = PIPE_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (drain) begin
                        state_d = PIPE_EMPTY;
                    end
                end
                PIPE_TWO: begin
                    if (drain) begin
                        state_d     = PIPE_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = PIPE_EMPTY;
            endcase
        end
        out_valid_d = (state_d != PIPE_EMPTY);
    end

    // Entries discarded by a flush: held ones not leaving this cycle plus
    // any input accepted in the same cycle.
    always_comb begin
        held_left = held_entries(state_q) - {1'b0, drain & (state_q != PIPE_EMPTY)};
        kill_inc  = flush ? (held_left + {1'b0, accept}) : 2'd0;
        stall_inc = {1'b0, hazard & in_valid};
    end

    // Stage state and payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PIPE_EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid_q}};
    assign out_data  = main_data_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_kill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (kill_inc),
        .cnt (kill_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 instance (16-bit counters)
// and one SKID=0 instance (2-bit counters) share the same stimulus; each has
// its own FIFO reference model and output monitor.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 96;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          hazard;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          cnt_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit SK = (g == 0);
        localparam int NW = (g == 0) ? 16 : 2;
        localparam int CMAX = (1 << NW) - 1;

        logic          in_ready;
        logic          out_valid;
        logic [CW-1:0] out_ctrl;
        logic [DW-1:0] out_data;
        logic [NW-1:0] stall_cnt;
        logic [NW-1:0] kill_cnt;

        logic [CW+DW-1:0] q[$];
        int  stall_m = 0;
        int  kill_m  = 0;
        int  n, kills;
        bit  ir, acc, drn;

        pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(SK), .CNT_W(NW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .hazard    (hazard),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_ctrl  (out_ctrl),
            .out_data  (out_data),
            .cnt_clr   (cnt_clr),
            .stall_cnt (stall_cnt),
            .kill_cnt  (kill_cnt)
        );

        // Reference model: a FIFO of at most 2 (SKID=1) or 1 (SKID=0) entries.
        always @(posedge clk) begin
            if (!rst) begin
                q.delete();
                stall_m = 0;
                kill_m  = 0;
            end else begin
                n   = q.size();
                ir  = !hazard && (SK ? (n < 2) : (n == 0 || out_ready));
                acc = in_valid && ir;
                drn = (n > 0) && out_ready;
                if (drn) void'(q.pop_front());
                kills = 0;
                if (flush) begin
                    kills = q.size() + (acc ? 1 : 0);
                    q.delete();
                end else if (acc) begin
                    q.push_back({in_ctrl, in_data});
                end
                if (cnt_clr) begin
                    stall_m = 0;
                    kill_m  = 0;
                end else begin
                    stall_m = stall_m + ((hazard && in_valid) ? 1 : 0);
                    if (stall_m > CMAX) stall_m = CMAX;
                    kill_m = kill_m + kills;
                    if (kill_m > CMAX) kill_m = CMAX;
                end
            end
        end

        // Monitor: compares what the DUT presents against the expected FIFO head.
        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("i%0d_rst_in_ready", g), 128'(in_ready), 128'(0));
                chk($sformatf("i%0d_rst_out_valid", g), 128'(out_valid), 128'(0));
                chk($sformatf("i%0d_rst_out_ctrl", g), 128'(out_ctrl), 128'(0));
                chk($sformatf("i%0d_rst_out_data", g), 128'(out_data), 128'(0));
                chk($sformatf("i%0d_rst_stall", g), 128'(stall_cnt), 128'(0));
                chk($sformatf("i%0d_rst_kill", g), 128'(kill_cnt), 128'(0));
            end else begin
                chk($sformatf("i%0d_in_ready", g), 128'(in_ready),
                    128'(!hazard && (SK ? (q.size() < 2) : (q.size() == 0 || out_ready))));
                chk($sformatf("i%0d_out_valid", g), 128'(out_valid), 128'(q.size() > 0));
                if (out_valid && q.size() > 0) begin
                    chk($sformatf("i%0d_out_entry", g), 128'({out_ctrl, out_data}), 128'(q[0]));
                end else if (!out_valid) begin
                    chk($sformatf("i%0d_bubble_ctrl", g), 128'(out_ctrl), 128'(0));
                end
                chk($sformatf("i%0d_stall_cnt", g), 128'(stall_cnt), 128'(stall_m));
                chk($sformatf("i%0d_kill_cnt", g), 128'(kill_cnt), 128'(kill_m));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hazard = 1'b0; in_valid = 1'b0;
        in_ctrl = '0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #1 rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;

        // streaming 1..4
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            put(CW'(i * 16 + i), DW'(i));
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // backpressure into the skid, then release
        out_ready = 1'b0;
        put(8'hA5, DW'(7)); cyc();
        put(8'h5A, DW'(9)); cyc();
        in_valid = 1'b0; repeat (2) cyc();
        out_ready = 1'b1; repeat (3) cyc();

        // flush with a full stage and a same-cycle input
        out_ready = 1'b0;
        put(8'h11, DW'(21)); cyc();
        put(8'h22, DW'(22)); cyc();
        put(8'h33, DW'(23)); flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; repeat (2) cyc();

        // hazard bubble starting from one held entry
        out_ready = 1'b1;
        put(8'h44, DW'(31)); cyc();
        hazard = 1'b1;
        repeat (4) begin put(8'h55, DW'(32)); cyc(); end
        hazard = 1'b0; in_valid = 1'b0; cyc();

        // saturation and clear-over-increment
        hazard = 1'b1; in_valid = 1'b1;
        repeat (5) cyc();
        cnt_clr = 1'b1; cyc();
        cnt_clr = 1'b0; hazard = 1'b0; in_valid = 1'b0; cyc();

        // toggling out_ready with continuous input
        for (int i = 0; i < 8; i++) begin
            put(CW'(i + 8'h60), DW'(100 + i));
            out_ready = (i % 2 == 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; repeat (3) cyc();

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            hazard    = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            if (i == 1500) rst = 1'b0;
            if (i == 1502) rst = 1'b1;
            cyc();
        end

        in_valid = 1'b0; hazard = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
